irq_baud_monitor: RTL

//  Multi-channel monitor for UART interrupt and baud_out lines in the UART test harness.
//  Per channel: synchronises IRQ and baud_out, latches IRQ rising edges as sticky pending bits,

---
 rtl/irq_mon_pkg.sv | 23 ++
 rtl/irq_mon_chan.sv | 126 ++++++++++++
 rtl/irq_baud_monitor.sv | 52 +++++
 3 files changed

// File: rtl/irq_mon_pkg.sv
// Shared types and helpers for the UART IRQ / baud_out monitor.
package irq_mon_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DIFF_W    = 33;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        MEAS  = 2'd2
    } baud_st_e;

    // One bit wider than any supported counter, so the unsigned difference cannot overflow.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/irq_mon_chan.sv
// One monitored channel: input sync, IRQ edge latch/count, baud period measurement and check.
//  state | meaning
//  IDLE  | no reference edge yet (reset or timeout), pc held at 0
//  ARMED | first baud edge seen, counting toward the first capture
//  MEAS  | at least one period captured, counting the next one
module irq_mon_chan
    import irq_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TOL         = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             irq_in,
    input  logic             baud_in,
    input  logic [CNT_W-1:0] exp_div,
    input  logic             clr,
    output logic             pend,
    output logic [CNT_W-1:0] irq_cnt,
    output logic [CNT_W-1:0] baud_period,
    output logic             baud_valid,
    output logic             baud_err
);

    localparam logic [CNT_W-1:0] CH_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] irq_sync;
    logic [SYNC_STAGES-1:0] baud_sync;
    logic                   irq_d;
    logic                   baud_d;
    logic                   irq_rise;
    logic                   baud_rise;
    logic [CNT_W-1:0]       pc;
    baud_st_e               st;
    logic                   chk_fail;
    logic [DIFF_W-1:0]      dev;
    logic                   out_of_tol;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            irq_sync  <= '0;
            baud_sync <= '0;
            irq_d     <= 1'b0;
            baud_d    <= 1'b0;
        end else begin
            irq_sync  <= {irq_sync[SYNC_STAGES-2:0], irq_in};
            baud_sync <= {baud_sync[SYNC_STAGES-2:0], baud_in};
            irq_d     <= irq_sync[SYNC_STAGES-1];
            baud_d    <= baud_sync[SYNC_STAGES-1];
        end
    end

    assign irq_rise  = irq_sync[SYNC_STAGES-1] & ~irq_d;
    assign baud_rise = baud_sync[SYNC_STAGES-1] & ~baud_d;

    // A rise coinciding with clr wins, so the event that arrived with the clear is kept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend    <= 1'b0;
            irq_cnt <= '0;
        end else begin
            if (irq_rise)
                pend <= 1'b1;
            else if (clr)
                pend <= 1'b0;

            if (clr)
                irq_cnt <= irq_rise ? CNT_W'(1) : '0;
            else if (irq_rise && (irq_cnt != CH_MAX))
                irq_cnt <= irq_cnt + CNT_W'(1);
        end
    end

    assign dev        = abs_diff(DIFF_W'(pc), DIFF_W'(exp_div));
    assign out_of_tol = (exp_div != '0) && (dev > DIFF_W'(TOL));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st          <= IDLE;
            pc          <= '0;
            baud_period <= '0;
            baud_valid  <= 1'b0;
            chk_fail    <= 1'b0;
        end else begin
            chk_fail <= 1'b0;
            case (st)
                IDLE: begin
                    pc <= '0;
                    if (baud_rise) begin
                        st <= ARMED;
                        pc <= CNT_W'(1);
                    end
                end
                ARMED, MEAS: begin
                    if (baud_rise) begin
                        baud_period <= pc;
                        baud_valid  <= 1'b1;
                        pc          <= CNT_W'(1);
                        st          <= MEAS;
                        chk_fail    <= out_of_tol;
                    end else if (pc == CH_MAX) begin
                        // Line stuck or stopped: drop the stale measurement and re-arm.
                        baud_valid <= 1'b0;
                        pc         <= '0;
                        st         <= IDLE;
                    end else begin
                        pc <= pc + CNT_W'(1);
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // Error lands one cycle after capture, so a clr on the capture cycle cannot hide it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            baud_err <= 1'b0;
        else if (chk_fail)
            baud_err <= 1'b1;
        else if (clr)
            baud_err <= 1'b0;
    end

endmodule

// File: rtl/irq_baud_monitor.sv
// Multi-channel UART IRQ / baud_out monitor with a masked, registered aggregate interrupt.
module irq_baud_monitor
    import irq_mon_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TOL         = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_CH-1:0]       irq_in,
    input  logic [NUM_CH-1:0]       baud_in,
    input  logic [NUM_CH*CNT_W-1:0] exp_div,
    input  logic [NUM_CH-1:0]       irq_mask,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH-1:0]       pend,
    output logic [NUM_CH*CNT_W-1:0] irq_cnt,
    output logic [NUM_CH*CNT_W-1:0] baud_period,
    output logic [NUM_CH-1:0]       baud_valid,
    output logic [NUM_CH-1:0]       baud_err,
    output logic                    irq_out
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        irq_mon_chan #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES),
            .TOL        (TOL)
        ) u_chan (
            .CLK        (CLK),
            .RST        (RST),
            .irq_in     (irq_in[i]),
            .baud_in    (baud_in[i]),
            .exp_div    (exp_div[i*CNT_W +: CNT_W]),
            .clr        (clr[i]),
            .pend       (pend[i]),
            .irq_cnt    (irq_cnt[i*CNT_W +: CNT_W]),
            .baud_period(baud_period[i*CNT_W +: CNT_W]),
            .baud_valid (baud_valid[i]),
            .baud_err   (baud_err[i])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            irq_out <= 1'b0;
        else
            irq_out <= |(pend & ~irq_mask);
    end

endmodule
